// File: rtl/nn_parameters.sv
// Shared sizes, widths and FSM encoding for the second dense layer.
package nn_parameters;

    localparam int IN_SIZE_2  = 4;
    localparam int OUT_SIZE_2 = 6;
    localparam int FRAC_BITS  = 12;
    localparam int DATA_W     = 24;
    localparam int PROD_W     = 2 * DATA_W;
    localparam int ACC_W      = PROD_W + $clog2(IN_SIZE_2);

    localparam int K_W = (IN_SIZE_2 > 1) ? $clog2(IN_SIZE_2) : 1;
    localparam int N_W = (OUT_SIZE_2 > 1) ? $clog2(OUT_SIZE_2) : 1;

    localparam logic [K_W-1:0] K_LAST = K_W'(IN_SIZE_2 - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(OUT_SIZE_2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/weight_rom_2.sv
// Weight and bias store for layer 2: synchronous read, one cycle of latency.
// The row (neuron) part of the address selects the bias, the full address the weight.
module weight_rom_2
    import nn_parameters::*;
(
    input  logic                     clk,
    input  logic [N_W+K_W-1:0]       addr,
    output logic signed [DATA_W-1:0] weight,
    output logic signed [DATA_W-1:0] bias
);

    logic [N_W-1:0]           row;
    logic [K_W-1:0]           col;
    logic signed [DATA_W-1:0] w_next;
    logic signed [DATA_W-1:0] b_next;

    assign row = addr[N_W+K_W-1:K_W];
    assign col = addr[K_W-1:0];

    // Table lookup; rows beyond the neuron count read as zero.
    always_comb begin
        w_next = '0;
        b_next = '0;
        case (row)
            N_W'(0): w_next = 24'h000800;
            N_W'(1): w_next = 24'h7FFFFF;
            N_W'(2): w_next = 24'hFFF000;
            N_W'(3): b_next = 24'h000C00;
            N_W'(4): begin
                w_next = 24'h000800;
                b_next = 24'hFFFC00;
            end
            N_W'(5): begin
                case (col)
                    K_W'(0): w_next = 24'h001000;
                    K_W'(1): w_next = 24'hFFF800;
                    K_W'(2): w_next = 24'h000300;
                    default: w_next = 24'h002000;
                endcase
                b_next = 24'h000100;
            end
            default: ;
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        weight <= w_next;
        bias   <= b_next;
    end

endmodule

// File: rtl/dense_layer_2_seq.sv
// Sequential dense layer 2: one multiplier walks every neuron and input in turn,
// then bias, saturation and ReLU are applied per neuron and all results are
// published together.
// Handshake: start is sampled only while in IDLE (busy=0); busy stays high for
// the whole run and done pulses for one cycle in the same cycle output_vector
// takes its new value.
module dense_layer_2_seq
    import nn_parameters::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] input_vector [IN_SIZE_2-1:0],
    output logic                     busy,
    output logic                     done,
    output logic signed [DATA_W-1:0] output_vector [OUT_SIZE_2-1:0],
    output state_t                   dbg_state
);

    localparam logic signed [ACC_W:0] R_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);

    state_t                   state;
    logic [N_W-1:0]           n;
    logic [K_W-1:0]           k;
    logic [K_W-1:0]           addr_k;
    logic signed [DATA_W-1:0] x_reg [IN_SIZE_2-1:0];
    logic signed [DATA_W-1:0] slots [OUT_SIZE_2-1:0];
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] rom_w;
    logic signed [DATA_W-1:0] rom_b;
    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  product_ext;
    logic signed [ACC_W:0]    bias_ext;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W:0]    r;
    logic signed [DATA_W-1:0] result;

    weight_rom_2 u_rom (
        .clk    (clk),
        .addr   ({n, addr_k}),
        .weight (rom_w),
        .bias   (rom_b)
    );

    // ROM column: in MAC the next column is prefetched; after the last column
    // it wraps to 0 so no out-of-range index is ever presented.
    always_comb begin
        addr_k = k;
        if (state == ST_MAC) begin
            addr_k = (k == K_LAST) ? '0 : k + K_W'(1);
        end
    end

    // The single shared multiplier and the bias/scale/saturate/ReLU datapath.
    always_comb begin
        product     = rom_w * x_reg[k];
        product_ext = $signed({{(ACC_W-PROD_W){product[PROD_W-1]}}, product});
        bias_ext    = $signed({{(ACC_W+1-DATA_W){rom_b[DATA_W-1]}}, rom_b});
        sum         = $signed({acc[ACC_W-1], acc}) + (bias_ext <<< FRAC_BITS);
        r           = sum >>> FRAC_BITS;
        // Negative values would saturate low and then be zeroed by ReLU anyway.
        if (r[ACC_W]) begin
            result = '0;
        end else if (r > R_MAX) begin
            result = 24'h7FFFFF;
        end else begin
            result = r[DATA_W-1:0];
        end
    end

    // Control FSM with accumulator, counters, working slots and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            n             <= '0;
            k             <= '0;
            acc           <= '0;
            done          <= 1'b0;
            x_reg         <= '{default: '0};
            slots         <= '{default: '0};
            output_vector <= '{default: '0};
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_reg <= input_vector;
                        n     <= '0;
                        k     <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    acc   <= '0;
                    k     <= '0;
                    state <= ST_MAC;
                end
                ST_MAC: begin
                    acc <= acc + product_ext;
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= ST_WRITE;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                ST_WRITE: begin
                    slots[n] <= result;
                    if (n == N_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        n     <= n + N_W'(1);
                        state <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    output_vector <= slots;
                    done          <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dense_layer_2_seq.sv
// Bench for dense_layer_2_seq: scenario tasks driving runs, a reference model
// feeding an expected-result queue, and inline comparisons on each done.
module tb_dense_layer_2_seq;
    import nn_parameters::*;

    localparam int LAT    = OUT_SIZE_2 * (IN_SIZE_2 + 2) + 1;
    localparam int XW     = IN_SIZE_2 * DATA_W;
    localparam int VW     = OUT_SIZE_2 * DATA_W;
    localparam int BUDGET = 200;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic signed [DATA_W-1:0] input_vector [IN_SIZE_2-1:0];
    logic                     busy;
    logic                     done;
    logic signed [DATA_W-1:0] output_vector [OUT_SIZE_2-1:0];
    state_t                   dbg_state;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [VW-1:0] exp_q[$];

    logic signed [DATA_W-1:0] w_tab [OUT_SIZE_2][IN_SIZE_2];
    logic signed [DATA_W-1:0] b_tab [OUT_SIZE_2];

    // Clock and DUT
    always #5 clk = ~clk;

    dense_layer_2_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .input_vector  (input_vector),
        .busy          (busy),
        .done          (done),
        .output_vector (output_vector),
        .dbg_state     (dbg_state)
    );

    // done pulses, counted on the edge after they appear
    always @(posedge clk) if (done === 1'b1) done_count++;

    // Reference model: floor-shifted Q12 dot product plus bias, clamp, ReLU
    function automatic logic [VW-1:0] model(input logic [XW-1:0] xv);
        logic [VW-1:0] res;
        longint acc;
        longint xk;
        longint wk;
        longint bb;
        longint rr;
        res = '0;
        for (int n = 0; n < OUT_SIZE_2; n++) begin
            acc = 0;
            for (int k = 0; k < IN_SIZE_2; k++) begin
                xk  = $signed(xv[k*DATA_W +: DATA_W]);
                wk  = w_tab[n][k];
                acc = acc + wk * xk;
            end
            bb  = b_tab[n];
            acc = acc + bb * 4096;
            rr  = acc >>> FRAC_BITS;
            if (rr < 0) rr = 0;
            else if (rr > 64'sd8388607) rr = 64'sd8388607;
            res[n*DATA_W +: DATA_W] = rr[DATA_W-1:0];
        end
        return res;
    endfunction

    function automatic logic [XW-1:0] fill(input logic [DATA_W-1:0] v);
        return {IN_SIZE_2{v}};
    endfunction

    // Driver: put a vector on input_vector
    task automatic drive_x(input logic [XW-1:0] xv);
        for (int k = 0; k < IN_SIZE_2; k++) input_vector[k] = xv[k*DATA_W +: DATA_W];
    endtask

    // Driver: one-cycle start pulse; returns at the negedge after acceptance
    task automatic start_run(input logic [XW-1:0] xv);
        @(negedge clk);
        drive_x(xv);
        start = 1'b1;
        exp_q.push_back(model(xv));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Driver: count edges until done is seen at a negedge, bounded
    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < BUDGET && !seen) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        drive_x('0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++;
        if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
        for (int n = 0; n < OUT_SIZE_2; n++) begin
            checks++;
            if (output_vector[n] !== 24'h0) begin errors++; $display("FAIL reset_out[%0d] got %h want 000000", n, output_vector[n]); end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_vector(input string name, input logic [XW-1:0] xv);
        int cyc;
        bit seen;
        logic [VW-1:0] e;
        start_run(xv);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy got %b want 1", name, busy); end
        wait_done(cyc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || cyc != LAT) begin errors++; $display("FAIL %s latency got %0d (seen %0d) want %0d", name, cyc, seen, LAT); end
        for (int n = 0; n < OUT_SIZE_2; n++) begin
            checks++;
            if (output_vector[n] !== e[n*DATA_W +: DATA_W]) begin
                errors++; $display("FAIL %s out[%0d] got %h want %h", name, n, output_vector[n], e[n*DATA_W +: DATA_W]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b want 0", name, done); end
    endtask

    task automatic test_nominal;
        test_vector("nominal", fill(24'h001000));
        checks++;
        if (output_vector[0] !== 24'(IN_SIZE_2 * 24'h000800)) begin
            errors++; $display("FAIL nominal_half out[0] got %h want %h", output_vector[0], 24'(IN_SIZE_2 * 24'h000800));
        end
        checks++;
        if (output_vector[2] !== 24'h000000) begin errors++; $display("FAIL nominal_neg out[2] got %h want 000000", output_vector[2]); end
    endtask

    task automatic test_saturation;
        test_vector("saturation", fill(24'h7FFFFF));
        checks++;
        if (output_vector[1] !== 24'h7FFFFF) begin errors++; $display("FAIL sat_max out[1] got %h want 7fffff", output_vector[1]); end
    endtask

    task automatic test_bias;
        test_vector("bias_only", '0);
        checks++;
        if (output_vector[3] !== 24'h000C00) begin errors++; $display("FAIL bias_pos out[3] got %h want 000c00", output_vector[3]); end
        checks++;
        if (output_vector[4] !== 24'h000000) begin errors++; $display("FAIL bias_neg out[4] got %h want 000000", output_vector[4]); end
    endtask

    task automatic test_random;
        logic [XW-1:0] xv;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < IN_SIZE_2; k++) xv[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 24'hFFFFFF));
            test_vector("random", xv);
        end
        for (int k = 0; k < IN_SIZE_2; k++) xv[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 24'h003FFF));
        test_vector("random_small", xv);
    endtask

    task automatic test_busy_restart;
        int cyc;
        bit seen;
        int base;
        logic [VW-1:0] e;
        base = done_count;
        start_run(fill(24'h001000));
        repeat (3) @(negedge clk);
        drive_x(fill(24'h7FFFFF));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        drive_x('0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, seen);
        e = exp_q.pop_front();
        checks++;
        if (!seen || cyc != LAT - 20) begin errors++; $display("FAIL busy_restart latency got %0d (seen %0d) want %0d", cyc, seen, LAT - 20); end
        for (int n = 0; n < OUT_SIZE_2; n++) begin
            checks++;
            if (output_vector[n] !== e[n*DATA_W +: DATA_W]) begin
                errors++; $display("FAIL busy_restart out[%0d] got %h want %h", n, output_vector[n], e[n*DATA_W +: DATA_W]);
            end
        end
        repeat (5) @(negedge clk);
        checks++;
        if (done_count - base != 1) begin errors++; $display("FAIL busy_restart pulses got %0d want 1", done_count - base); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL busy_restart idle got %b want 0", busy); end
    endtask

    task automatic test_reset_mid;
        int base;
        logic [VW-1:0] e;
        start_run(fill(24'h001000));
        repeat (8) @(negedge clk);
        checks++;
        if (dbg_state !== ST_MAC) begin errors++; $display("FAIL reset_mid pre_state got %0d want %0d", dbg_state, ST_MAC); end
        e = exp_q.pop_back();
        base = done_count;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid busy got %b want 0", busy); end
        for (int n = 0; n < OUT_SIZE_2; n++) begin
            checks++;
            if (output_vector[n] !== 24'h0) begin errors++; $display("FAIL reset_mid out[%0d] got %h want 000000", n, output_vector[n]); end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        checks++;
        if (done_count != base) begin errors++; $display("FAIL reset_mid stray_done got %0d want 0", done_count - base); end
        test_vector("after_reset", fill(24'h000800));
    endtask

    task automatic test_back_to_back;
        int cyc;
        bit seen;
        logic [VW-1:0] e;
        logic [XW-1:0] xv;
        xv = fill(24'hFFF800);
        xv[DATA_W-1:0] = 24'h003000;
        @(negedge clk);
        drive_x(xv);
        start = 1'b1;
        exp_q.push_back(model(xv));
        exp_q.push_back(model(xv));
        for (int run = 0; run < 2; run++) begin
            wait_done(cyc, seen);
            if (run == 1) start = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (!seen || cyc != LAT + 1) begin errors++; $display("FAIL b2b spacing[%0d] got %0d (seen %0d) want %0d", run, cyc, seen, LAT + 1); end
            for (int n = 0; n < OUT_SIZE_2; n++) begin
                checks++;
                if (output_vector[n] !== e[n*DATA_W +: DATA_W]) begin
                    errors++; $display("FAIL b2b[%0d] out[%0d] got %h want %h", run, n, output_vector[n], e[n*DATA_W +: DATA_W]);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b stop got busy %b want 0", busy); end
    endtask

    initial begin
        for (int n = 0; n < OUT_SIZE_2; n++) begin
            b_tab[n] = '0;
            for (int k = 0; k < IN_SIZE_2; k++) w_tab[n][k] = '0;
        end
        for (int k = 0; k < IN_SIZE_2; k++) begin
            w_tab[0][k] = 24'h000800;
            w_tab[1][k] = 24'h7FFFFF;
            w_tab[2][k] = 24'hFFF000;
            w_tab[4][k] = 24'h000800;
        end
        b_tab[3] = 24'h000C00;
        b_tab[4] = 24'hFFFC00;
        w_tab[5][0] = 24'h001000;
        w_tab[5][1] = 24'hFFF800;
        w_tab[5][2] = 24'h000300;
        w_tab[5][3] = 24'h002000;
        b_tab[5] = 24'h000100;

        test_reset;
        test_nominal;
        test_saturation;
        test_bias;
        test_random;
        test_busy_restart;
        test_reset_mid;
        test_back_to_back;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_layer_2_seq.md
DENSE_LAYER_2_SEQ -- requirements
Module: dense_layer_2_seq

Interface
REQ-001 SHALL use package constants: IN_SIZE_2 (inputs per neuron), OUT_SIZE_2 (neurons), FRAC_BITS = 12 (signed Q12.12 data).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request one layer evaluation.
REQ-005 SHALL have port input_vector [IN_SIZE_2-1:0], input, 24 bits each: signed Q12.12 activations from layer 1.
REQ-006 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse when output_vector updates.
REQ-008 SHALL have port output_vector [OUT_SIZE_2-1:0], output, 24 bits each: signed Q12.12 results, which feed dropout_layer_2.

Function
REQ-009 SHALL implement FSM states IDLE, FETCH, MAC, WRITE and DONE.
REQ-010 In IDLE, start=1 SHALL capture input_vector into an internal register, clear the neuron index n and the input index k, and go to FETCH.
REQ-011 FETCH SHALL last one cycle: issue ROM address (n,0), clear the accumulator, then go to MAC.
REQ-012 MAC SHALL last IN_SIZE_2 cycles, each adding sign-extended w[n][k]*x[k] (48-bit product) to the accumulator and prefetching (n,k+1).
REQ-013 Accumulator width SHALL be 48+$clog2(IN_SIZE_2) bits, so no overflow occurs inside MAC.
REQ-014 WRITE SHALL last one cycle and compute r = (acc + (bias[n] <<< FRAC_BITS)) >>> FRAC_BITS, using an arithmetic shift that rounds toward -inf.
REQ-015 In WRITE, r SHALL saturate to [-2^23, 2^23-1], apply ReLU (negative -> 0), and be stored in working slot n.
REQ-016 After WRITE, the FSM SHALL go to FETCH with n+1, or go to DONE when n = OUT_SIZE_2-1.
REQ-017 DONE SHALL last one cycle: copy all working slots into output_vector atomically, assert done, and return to IDLE.
REQ-018 done SHALL be high exactly OUT_SIZE_2*(IN_SIZE_2+2)+1 cycles after the clock edge that accepted start.
REQ-019 output_vector SHALL change only in DONE and SHALL otherwise hold its last value.
REQ-020 start while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-021 start asserted in the DONE cycle SHALL be ignored; start is accepted from the following IDLE cycle.
REQ-022 Changes on input_vector after acceptance SHALL NOT affect the running computation.
REQ-023 Counter wrap: k SHALL run 0..IN_SIZE_2-1 and n SHALL run 0..OUT_SIZE_2-1; index values at or beyond the size SHALL never address the ROM.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, all output_vector entries to 0, and clear accumulator, counters and working slots.
REQ-025 Reset asserted mid-operation SHALL abort the computation without producing a done pulse; the first start after reset release SHALL run a full evaluation.

Structure
REQ-026 IN_SIZE_2, OUT_SIZE_2, FRAC_BITS, ACC_W and the FSM state enum typedef SHALL reside in nn_parameters.
REQ-027 Weights and biases SHALL sit in one sub-module, weight_rom_2, with synchronous read and 1-cycle latency.
REQ-028 weight_rom_2 SHALL take address {n,k} and return w[n][k] and bias[n] as signed 24-bit values.
REQ-029 dense_layer_2_seq SHALL use one multiplier only (time-multiplexed MAC).

Verification
REQ-030 Nominal: all x=0x001000 (1.0), all w=0x000800 (0.5), bias=0 -> every output = IN_SIZE_2*0x000800, and done arrives at the latency in REQ-018.
REQ-031 Saturation/ReLU: x=0x7FFFFF, w=0x7FFFFF -> outputs 0x7FFFFF; w=0xFFF000 (-1.0) with x=0x001000 -> outputs 0x000000.
REQ-032 Bias only: x=0 with bias[n]=0x000400*n -> output[n]=0x000400*n; with bias[n]=-0x000400 -> 0.
REQ-033 start re-pulsed while busy, and input_vector changed mid-run -> a single done pulse, and results match the originally captured inputs.
REQ-034 rst_n dropped during MAC of neuron 1 -> outputs 0, busy 0 at once, and no done; a subsequent start gives correct results.
REQ-035 Back-to-back runs with start held high -> consecutive done pulses spaced OUT_SIZE_2*(IN_SIZE_2+2)+2 cycles apart.
